mdio_peripheral: RTL and testbench

MDIO_PERIPHERAL -- requirements
Module: mdio_peripheral

---
 rtl/mdio_peripheral.sv | 133 +++++++++++++
 tb/tb_mdio_peripheral.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mdio_peripheral.sv
// mdio_peripheral: MDIO register-access slave; define MDIO_PREAMBLE_SUPPRESS_EN to accept ST after a single preamble 1
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  output logic        mdio_in,
  output logic        mdio_oe,
  output logic [4:0]  addr,
  output logic [15:0] wr_data,
  output logic        wr_stb,
  input  logic [15:0] rd_data
);
  typedef enum logic [2:0] {IDLE, START, OP, PHYAD, REGAD, TA, WR_DATA, RD_DATA} state_t;
  state_t      state, state_n;
  logic        mdc_q, rise, fall, pre_ok, rd, rd_n, oe_n, in_n, stb_n;
  logic [5:0]  cnt, cnt_n;
  logic [4:0]  bits, bits_n, sh5, sh5_n, sh5_nx, addr_n;
  logic [15:0] sh, sh_n, wd_n;
  assign rise   = mdc & ~mdc_q;
  assign fall   = ~mdc & mdc_q;
  assign sh5_nx = {sh5[3:0], mdio_out};
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = cnt != 6'd0;
`else
  assign pre_ok = cnt == 6'd32;
`endif
  // frame decode on MDC rises, read-data drive on MDC falls
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bits_n  = bits;
    sh5_n   = sh5;
    addr_n  = addr;
    wd_n    = wr_data;
    rd_n    = rd;
    sh_n    = sh;
    oe_n    = mdio_oe;
    in_n    = mdio_in;
    stb_n   = 1'b0;
    if (rise) begin
      bits_n = bits + 5'd1;
      case (state)
        IDLE: begin
          bits_n  = 5'd0;
          cnt_n   = !mdio_out ? 6'd0 : cnt == 6'd32 ? cnt : cnt + 6'd1;
          state_n = (!mdio_out && pre_ok) ? START : IDLE;
        end
        START: begin
          bits_n  = 5'd0;
          state_n = mdio_out ? OP : IDLE;
        end
        OP: begin
          rd_n = bits == 5'd0 ? mdio_out : rd;
          if (bits == 5'd1) begin
            bits_n  = 5'd0;
            state_n = rd != mdio_out ? PHYAD : IDLE;
          end
        end
        PHYAD: begin
          sh5_n = sh5_nx;
          if (bits == 5'd4) begin
            bits_n  = 5'd0;
            state_n = sh5_nx == PHY_ADDR ? REGAD : IDLE;
          end
        end
        REGAD: begin
          sh5_n = sh5_nx;
          if (bits == 5'd4) begin
            bits_n  = 5'd0;
            addr_n  = sh5_nx;
            sh_n    = rd ? rd_data : sh;
            state_n = TA;
          end
        end
        TA: begin
          if (bits == 5'd1) begin
            bits_n  = 5'd0;
            state_n = rd ? RD_DATA : !mdio_out ? WR_DATA : IDLE;
          end else if (!rd && !mdio_out) begin
            state_n = IDLE;
          end
        end
        WR_DATA: begin
          wd_n = {wr_data[14:0], mdio_out};
          if (bits == 5'd15) begin
            stb_n   = 1'b1;
            state_n = IDLE;
          end
        end
        RD_DATA: state_n = bits == 5'd15 ? IDLE : RD_DATA;
        default: state_n = IDLE;
      endcase
    end
    if (fall) begin
      oe_n = state == RD_DATA || (state == TA && rd && bits == 5'd1);
      in_n = state == RD_DATA && sh[15];
      sh_n = state == RD_DATA ? {sh[14:0], 1'b0} : sh;
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      bits    <= 5'd0;
      sh5     <= 5'd0;
      mdc_q   <= 1'b0;
      rd      <= 1'b0;
      sh      <= 16'd0;
      mdio_oe <= 1'b0;
      mdio_in <= 1'b0;
      addr    <= 5'd0;
      wr_data <= 16'd0;
      wr_stb  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bits    <= bits_n;
      sh5     <= sh5_n;
      mdc_q   <= mdc;
      rd      <= rd_n;
      sh      <= sh_n;
      mdio_oe <= oe_n;
      mdio_in <= in_n;
      addr    <= addr_n;
      wr_data <= wd_n;
      wr_stb  <= stb_n;
    end
  end
endmodule

// File: tb/tb_mdio_peripheral.sv
// tb_mdio_peripheral: directed frame-level checks of mdio_peripheral
module tb_mdio_peripheral;
  logic        clk = 0, reset = 1, mdc = 0, mdio_out = 1;
  logic        mdio_in, mdio_oe, wr_stb;
  logic [4:0]  addr;
  logic [15:0] wr_data, rd_data = 16'd0;
  int          n_chk = 0, n_fail = 0, stb_cnt = 0, oe_cnt = 0, viol = 0;
  logic        last_oe, last_in;
  logic        rd_oe [19];
  logic        rd_in [19];
  mdio_peripheral #(.PHY_ADDR(5'd1)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_out(mdio_out), .mdio_in(mdio_in),
    .mdio_oe(mdio_oe), .addr(addr), .wr_data(wr_data), .wr_stb(wr_stb), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_stb) stb_cnt++;
    if (mdio_oe) oe_cnt++;
    if (!mdio_oe && mdio_in) viol++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mbit(input logic b);
    mdio_out = b;
    mdc = 0;
    repeat (4) @(negedge clk);
    last_oe = mdio_oe;
    last_in = mdio_in;
    mdc = 1;
    repeat (4) @(negedge clk);
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mbit(v[i]);
  endtask
  task automatic ones(input int n);
    repeat (n) mbit(1'b1);
  endtask
  task automatic hdr(input logic rd, input logic [4:0] phy, input logic [4:0] ra);
    send(rd ? 32'b0110 : 32'b0101, 4);
    send({27'd0, phy}, 5);
    send({27'd0, ra}, 5);
  endtask
  task automatic wr_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    hdr(1'b0, phy, ra);
    send(32'b10, 2);
    send({16'd0, d}, 16);
  endtask
  int s0, o0;
  logic [18:0] oe_v;
  logic [15:0] d_v;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_oe", {31'd0, mdio_oe}, 0);
    chk("rst_in", {31'd0, mdio_in}, 0);
    chk("rst_addr", {27'd0, addr}, 0);
    chk("rst_wdata", {16'd0, wr_data}, 0);
    chk("rst_stb", {31'd0, wr_stb}, 0);
    reset = 0;
    @(negedge clk);
    s0 = stb_cnt;
    ones(32);
    wr_frame(5'd1, 5'd3, 16'hA5C3);
    ones(2);
    chk("wr_stb_count", stb_cnt - s0, 1);
    chk("wr_addr", {27'd0, addr}, 32'd3);
    chk("wr_data", {16'd0, wr_data}, 32'hA5C3);
    s0 = stb_cnt;
    ones(20);
    wr_frame(5'd1, 5'd5, 16'h1111);
    ones(2);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    chk("short_pre_stb", stb_cnt - s0, 1);
`else
    chk("short_pre_stb", stb_cnt - s0, 0);
`endif
    rd_data = 16'h1234;
    s0 = stb_cnt;
    ones(32);
    hdr(1'b1, 5'd1, 5'd2);
    for (int i = 0; i < 19; i++) begin
      mbit(1'b1);
      rd_oe[i] = last_oe;
      rd_in[i] = last_in;
    end
    for (int i = 0; i < 19; i++) oe_v[i] = rd_oe[i];
    for (int i = 2; i < 18; i++) d_v = {d_v[14:0], rd_in[i]};
    chk("rd_oe_pattern", {13'd0, oe_v}, 32'h3FFFE);
    chk("rd_ta_in", {31'd0, rd_in[1]}, 0);
    chk("rd_data_bits", {16'd0, d_v}, 32'h1234);
    chk("rd_end_in", {31'd0, rd_in[18]}, 0);
    chk("rd_addr", {27'd0, addr}, 32'd2);
    chk("rd_no_stb", stb_cnt - s0, 0);
    s0 = stb_cnt;
    o0 = oe_cnt;
    ones(32);
    send(32'b0111, 4);
    send(32'b00001_00100_10, 12);
    ones(4);
    chk("op11_stb", stb_cnt - s0, 0);
    chk("op11_oe", oe_cnt - o0, 0);
    rd_data = 16'hBEEF;
    ones(32);
    hdr(1'b1, 5'd1, 5'd7);
    ones(9);
    mdio_out = 1;
    mdc = 0;
    repeat (2) @(negedge clk);
    chk("rst_mid_oe_before", {31'd0, mdio_oe}, 1);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_oe", {31'd0, mdio_oe}, 0);
    chk("rst_mid_in", {31'd0, mdio_in}, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    mdc = 1;
    repeat (4) @(negedge clk);
    s0 = stb_cnt;
    ones(32);
    wr_frame(5'd1, 5'd9, 16'hFFFF);
    ones(2);
    chk("post_rst_stb", stb_cnt - s0, 1);
    chk("post_rst_addr", {27'd0, addr}, 32'd9);
    chk("post_rst_data", {16'd0, wr_data}, 32'hFFFF);
    s0 = stb_cnt;
    o0 = oe_cnt;
    ones(32);
    send(32'b0101, 4);
    send(32'b00111, 5);
    chk("badphy_stb", stb_cnt - s0, 0);
    chk("badphy_oe", oe_cnt - o0, 0);
    send(32'b00011_10, 7);
    send(32'hA5C3, 16);
    wr_frame(5'd1, 5'd4, 16'h0F0F);
    ones(2);
`ifndef MDIO_PREAMBLE_SUPPRESS_EN
    chk("nopre_stb", stb_cnt - s0, 0);
    chk("nopre_oe", oe_cnt - o0, 0);
    chk("nopre_addr", {27'd0, addr}, 32'd9);
`endif
    chk("in_without_oe", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
